// File: rtl/branch_resolve_ctrl_if.sv
// Branch request channel between ID/EX and the branch resolution controller.
// The requester (master) presents one conditional branch with its operands and
// fetch-time prediction; the controller (slave) answers with br_ready.
interface branch_resolve_ctrl_if #(
   parameter int XLEN = 64
);
   logic            br_valid;
   logic            br_ready;
   logic [2:0]      br_funct3;
   logic [XLEN-1:0] br_rs1;
   logic [XLEN-1:0] br_rs2;
   logic [XLEN-1:0] br_pc;
   logic [XLEN-1:0] br_imm;
   logic            br_pred_taken;

   modport master (
      output br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, br_pred_taken,
      input  br_ready
   );

   modport slave (
      input  br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, br_pred_taken,
      output br_ready
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution controller.
// Resolves one conditional branch per accepted handshake, trains a bimodal
// table of 2-bit saturating counters, and on a mispredict issues a one-cycle
// PC redirect together with a multi-cycle flush of the front-end stages.
// The same table answers the IF-stage prediction lookup combinationally.
module branch_resolve_ctrl #(
   parameter int XLEN         = 64,
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [XLEN-1:0]      if_pc,
   output logic                 if_pred_taken,
   branch_resolve_ctrl_if.slave br,
   output logic                 redirect_valid,
   output logic [XLEN-1:0]      redirect_pc,
   output logic                 flush,
   output logic [CNT_W-1:0]     stat_branches,
   output logic [CNT_W-1:0]     stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   // Flush counter starts at FLUSH_CYCLES-1 and leaves FLUSH when it reaches 0.
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FLUSH_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_ZERO  = {FC_W{1'b0}};
   localparam logic [FC_W-1:0]  FC_ONE   = {{(FC_W-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]  PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0]  PC_ZERO  = {XLEN{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       BHT_INIT = 2'b01;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nx;
   logic [FC_W-1:0]   fcnt_r;
   logic [FC_W-1:0]   fcnt_nx;

   logic [1:0]        bht_r [BHT_ENTRIES];
   logic              redirect_valid_r;
   logic [XLEN-1:0]   redirect_pc_r;
   logic [CNT_W-1:0]  stat_branches_r;
   logic [CNT_W-1:0]  stat_mispredicts_r;

   logic              taken_s;
   logic              legal_s;
   logic              accept_s;
   logic              update_s;
   logic              mispred_s;
   logic [XLEN-1:0]   target_s;
   logic [IDX_W-1:0]  br_idx_s;
   logic [IDX_W-1:0]  if_idx_s;
   logic              unused_if_pc_s;

   // Saturating 2-bit counter step: toward 11 when taken, toward 00 otherwise.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      if (up) begin
         res = (cnt == 2'b11) ? 2'b11 : (cnt + 2'b01);
      end else begin
         res = (cnt == 2'b00) ? 2'b00 : (cnt - 2'b01);
      end
      return res;
   endfunction

   // The table is indexed by word address; PC bits [1:0] never matter.
   assign br_idx_s       = br.br_pc[IDX_W+1:2];
   assign if_idx_s       = if_pc[IDX_W+1:2];
   assign unused_if_pc_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

   // No bypass: a lookup of the entry being written this cycle sees the old value.
   assign if_pred_taken  = bht_r[if_idx_s][1];

   assign br.br_ready       = (state_r == ST_IDLE);
   assign flush             = (state_r == ST_FLUSH);
   assign redirect_valid    = redirect_valid_r;
   assign redirect_pc       = redirect_pc_r;
   assign stat_branches     = stat_branches_r;
   assign stat_mispredicts  = stat_mispredicts_r;

   // Branch condition evaluation; funct3 010/011 are not branches.
   always_comb begin
      taken_s = 1'b0;
      legal_s = 1'b1;
      case (br.br_funct3)
         3'b000:  taken_s = (br.br_rs1 == br.br_rs2);
         3'b001:  taken_s = (br.br_rs1 != br.br_rs2);
         3'b100:  taken_s = ($signed(br.br_rs1) <  $signed(br.br_rs2));
         3'b101:  taken_s = ($signed(br.br_rs1) >= $signed(br.br_rs2));
         3'b110:  taken_s = (br.br_rs1 <  br.br_rs2);
         3'b111:  taken_s = (br.br_rs1 >= br.br_rs2);
         default: legal_s = 1'b0;
      endcase
   end

   // Handshake qualification and the corrected fetch target (wraps mod 2^XLEN).
   always_comb begin
      accept_s  = br.br_valid & (state_r == ST_IDLE);
      update_s  = accept_s & legal_s;
      mispred_s = update_s & (taken_s ^ br.br_pred_taken);
      if (taken_s) begin
         target_s = br.br_pc + br.br_imm;
      end else begin
         target_s = br.br_pc + PC_STEP;
      end
   end

   // FSM next state: a mispredict holds FLUSH for FLUSH_CYCLES cycles.
   always_comb begin
      state_nx = state_r;
      fcnt_nx  = fcnt_r;
      case (state_r)
         ST_IDLE: begin
            if (mispred_s) begin
               state_nx = ST_FLUSH;
               fcnt_nx  = FC_LAST;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (fcnt_r == FC_ZERO) begin
               state_nx = ST_IDLE;
            end else begin
               fcnt_nx = fcnt_r - FC_ONE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            fcnt_nx  = FC_ZERO;
         end
      endcase
   end

   // FSM state and flush-length counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         fcnt_r  <= FC_ZERO;
      end else begin
         state_r <= state_nx;
         fcnt_r  <= fcnt_nx;
      end
   end

   // Redirect pulse and held redirect target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= PC_ZERO;
      end else begin
         redirect_valid_r <= mispred_s;
         if (mispred_s) begin
            redirect_pc_r <= target_s;
         end
      end
   end

   // Resolution statistics, free-running with natural wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_r    <= CNT_ZERO;
         stat_mispredicts_r <= CNT_ZERO;
      end else begin
         if (update_s) begin
            stat_branches_r <= stat_branches_r + CNT_ONE;
         end
         if (mispred_s) begin
            stat_mispredicts_r <= stat_mispredicts_r + CNT_ONE;
         end
      end
   end

   // Bimodal history table training on every legal accepted branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_r[i] <= BHT_INIT;
         end
      end else begin
         if (update_s) begin
            bht_r[br_idx_s] <= sat_update(bht_r[br_idx_s], taken_s);
         end
      end
   end

endmodule
